traffic_light_actuated_controller: RTL and testbench

- Parametrised, sensor-actuated successor to the fixed-sequence two-road traffic light FSM.
- Per-phase durations are counter-timed.
- Adds vehicle-demand sensing (min-green gap-out, rest-on-green) and a latched pedestrian walk phase.
- Sits at intersection-controller top level; drives lamp encodings for NS and EW heads plus a walk lamp.

---
 rtl/tlc_pkg.sv | 54 +++++
 rtl/tlc_phase_timer.sv | 35 +++
 rtl/traffic_light_actuated_controller.sv | 186 ++++++++++++++++++
 tb/tb_traffic_light_actuated_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg
// Shared types and constants for the actuated two-road traffic light
// controller.
//   - tlc_state_e : 3-bit FSM state encoding. The codes are visible on state_o.
//   - LAMP_*      : 2-bit lamp encodings used for both vehicle heads.
//   - lamp_ns / lamp_ew / walk_on : Moore output decode from a state.
// Optional build macro used elsewhere: TLC_FLASH_EN (flash mode).
// ---------------------------------------------------------------------------
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_ALL_RED   = 3'd0,
        ST_NS_GREEN  = 3'd1,
        ST_NS_YELLOW = 3'd2,
        ST_CLR_NS    = 3'd3,
        ST_EW_GREEN  = 3'd4,
        ST_EW_YELLOW = 3'd5,
        ST_CLR_EW    = 3'd6,
        ST_PED_WALK  = 3'd7
    } tlc_state_e;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_DARK   = 2'b11;

    function automatic logic [1:0] lamp_ns(input tlc_state_e s);
        logic [1:0] l;
        l = LAMP_RED;
        case (s)
            ST_NS_GREEN:  l = LAMP_GREEN;
            ST_NS_YELLOW: l = LAMP_YELLOW;
            default:      l = LAMP_RED;
        endcase
        return l;
    endfunction

    function automatic logic [1:0] lamp_ew(input tlc_state_e s);
        logic [1:0] l;
        l = LAMP_RED;
        case (s)
            ST_EW_GREEN:  l = LAMP_GREEN;
            ST_EW_YELLOW: l = LAMP_YELLOW;
            default:      l = LAMP_RED;
        endcase
        return l;
    endfunction

    function automatic logic walk_on(input tlc_state_e s);
        return (s == ST_PED_WALK);
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// ---------------------------------------------------------------------------
// tlc_phase_timer
// Phase timer for the traffic light FSM: clears to zero, otherwise counts up
// by one per clock and saturates at all-ones, so a long rest-on-green
// cannot wrap back into the low "elapsed" range.
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous active-high reset (count -> 0)
//   i_clear  : synchronous clear, takes effect on the next edge
//   o_count  : current count
// ---------------------------------------------------------------------------
module tlc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != {CNT_W{1'b1}}) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/traffic_light_actuated_controller.sv
// ---------------------------------------------------------------------------
// traffic_light_actuated_controller
// Sensor-actuated two-road traffic light with min-green gap-out, max-green
// max-out, rest-on-green and a latched pedestrian walk phase.
// Optional feature macro: TLC_FLASH_EN (adds flash_req input and the
// FLASH_HALF_CYCLES parameter; flash reuses state code 0 plus a flag).
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   flash_req : (TLC_FLASH_EN only) force flashing yellow/red
//   car_NS    : NS vehicle-present sensor, level
//   car_EW    : EW vehicle-present sensor, level
//   ped_req   : pedestrian button, latched internally
//   light_NS  : NS lamp (00 red, 10 green, 01 yellow, 11 dark)
//   light_EW  : EW lamp, same encoding
//   walk      : pedestrian walk lamp
//   state_o   : current FSM state code
// All outputs are registers loaded from the next state, so they always
// equal the decode of the state register and have no input-to-output path.
// ---------------------------------------------------------------------------
module traffic_light_actuated_controller
    import tlc_pkg::*;
#(
    parameter int CNT_W             = 8,
    parameter int GREEN_CYCLES      = 8,
    parameter int MIN_GREEN_CYCLES  = 3,
    parameter int YELLOW_CYCLES     = 3,
    parameter int ALLRED_CYCLES     = 2,
`ifdef TLC_FLASH_EN
    parameter int FLASH_HALF_CYCLES = 4,
`endif
    parameter int WALK_CYCLES       = 6
) (
    input  logic       clk,
    input  logic       reset,
`ifdef TLC_FLASH_EN
    input  logic       flash_req,
`endif
    input  logic       car_NS,
    input  logic       car_EW,
    input  logic       ped_req,
    output logic [1:0] light_NS,
    output logic [1:0] light_EW,
    output logic       walk,
    output logic [2:0] state_o
);

    // "Elapsed N" is the cycle in which the timer reads N-1.
    localparam logic [CNT_W-1:0] GREEN_M1  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_M1    = CNT_W'(MIN_GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] WALK_M1   = CNT_W'(WALK_CYCLES - 1);
`ifdef TLC_FLASH_EN
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(FLASH_HALF_CYCLES - 1);
`endif

    tlc_state_e       r_state;
    logic             r_ped_pending;
    logic             r_last_ew;      // 1: EW green was entered most recently
    logic [1:0]       r_light_ns;
    logic [1:0]       r_light_ew;
    logic             r_walk;

    tlc_state_e       w_next;
    logic             w_clear;
    logic             w_ped_clear;
    logic [CNT_W-1:0] w_timer;
    logic             w_ns_exit;
    logic             w_ew_exit;

`ifdef TLC_FLASH_EN
    logic             r_flash;
    logic             r_flash_phase;  // 0: yellow/red, 1: dark/dark
    logic             w_flash_next;
    logic             w_phase_next;
`endif

    tlc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clear (w_clear),
        .o_count (w_timer)
    );

    // Green exit: gap-out once min green is served and only the opposing
    // road has a car; max-out once max green is served and someone else
    // (opposing car or pedestrian) is waiting.
    assign w_ns_exit = ((w_timer >= MIN_M1) && car_EW && !car_NS) ||
                       ((w_timer >= GREEN_M1) && (car_EW || r_ped_pending));
    assign w_ew_exit = ((w_timer >= MIN_M1) && car_NS && !car_EW) ||
                       ((w_timer >= GREEN_M1) && (car_NS || r_ped_pending));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ALL_RED:   if (w_timer == ALLRED_M1) w_next = ST_NS_GREEN;
            ST_NS_GREEN:  if (w_ns_exit) w_next = ST_NS_YELLOW;
            ST_NS_YELLOW: if (w_timer == YELLOW_M1) w_next = ST_CLR_NS;
            ST_CLR_NS:    if (w_timer == ALLRED_M1)
                              w_next = r_ped_pending ? ST_PED_WALK : ST_EW_GREEN;
            ST_EW_GREEN:  if (w_ew_exit) w_next = ST_EW_YELLOW;
            ST_EW_YELLOW: if (w_timer == YELLOW_M1) w_next = ST_CLR_EW;
            ST_CLR_EW:    if (w_timer == ALLRED_M1)
                              w_next = r_ped_pending ? ST_PED_WALK : ST_NS_GREEN;
            ST_PED_WALK:  if (w_timer == WALK_M1)
                              w_next = r_last_ew ? ST_NS_GREEN : ST_EW_GREEN;
            default:      w_next = ST_ALL_RED;
        endcase
        w_clear     = (w_next != r_state);
        w_ped_clear = (w_next == ST_PED_WALK) && (r_state != ST_PED_WALK);
`ifdef TLC_FLASH_EN
        w_flash_next = flash_req;
        w_phase_next = r_flash_phase;
        if (flash_req) begin
            // Flash parks the state register at ALL_RED and borrows the
            // phase timer to pace the lamp toggle.
            w_next      = ST_ALL_RED;
            w_ped_clear = 1'b0;
            if (!r_flash) begin
                w_clear      = 1'b1;
                w_phase_next = 1'b0;
            end else if (w_timer == HALF_M1) begin
                w_clear      = 1'b1;
                w_phase_next = ~r_flash_phase;
            end else begin
                w_clear      = 1'b0;
            end
        end else if (r_flash) begin
            // Leaving flash restarts a full all-red clearance.
            w_next      = ST_ALL_RED;
            w_clear     = 1'b1;
            w_ped_clear = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_ALL_RED;
            r_ped_pending <= 1'b0;
            r_last_ew     <= 1'b0;
            r_light_ns    <= LAMP_RED;
            r_light_ew    <= LAMP_RED;
            r_walk        <= 1'b0;
`ifdef TLC_FLASH_EN
            r_flash       <= 1'b0;
            r_flash_phase <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            // A new press in the same cycle as the walk entry wins.
            r_ped_pending <= ped_req | (r_ped_pending & ~w_ped_clear);
            if (w_next == ST_NS_GREEN) begin
                r_last_ew <= 1'b0;
            end else if (w_next == ST_EW_GREEN) begin
                r_last_ew <= 1'b1;
            end
`ifdef TLC_FLASH_EN
            r_flash       <= w_flash_next;
            r_flash_phase <= w_phase_next;
            if (w_flash_next) begin
                r_light_ns <= w_phase_next ? LAMP_DARK : LAMP_YELLOW;
                r_light_ew <= w_phase_next ? LAMP_DARK : LAMP_RED;
                r_walk     <= 1'b0;
            end else begin
                r_light_ns <= lamp_ns(w_next);
                r_light_ew <= lamp_ew(w_next);
                r_walk     <= walk_on(w_next);
            end
`else
            r_light_ns <= lamp_ns(w_next);
            r_light_ew <= lamp_ew(w_next);
            r_walk     <= walk_on(w_next);
`endif
        end
    end

    assign light_NS = r_light_ns;
    assign light_EW = r_light_ew;
    assign walk     = r_walk;
    assign state_o  = r_state;

endmodule

// File: tb/tb_traffic_light_actuated_controller.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_actuated_controller
// Directed scenarios plus randomized sensor/button traffic, checked cycle by
// cycle against a phase/elapsed-cycle model of the controller rules.
// Define TLC_FLASH_EN to also exercise flash mode.
// ---------------------------------------------------------------------------
module tb_traffic_light_actuated_controller;

    localparam int GREEN  = 8;
    localparam int MING   = 3;
    localparam int YELLOW = 3;
    localparam int ALLRED = 2;
    localparam int WALKC  = 6;

    // Phase codes as seen on state_o.
    localparam int P_ALLRED = 0, P_NSG = 1, P_NSY = 2, P_CLRNS = 3;
    localparam int P_EWG = 4, P_EWY = 5, P_CLREW = 6, P_WALK = 7;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       car_NS, car_EW, ped_req;
    logic [1:0] light_NS, light_EW;
    logic       walk;
    logic [2:0] state_o;
`ifdef TLC_FLASH_EN
    logic       flash_req;
`endif

    always #5 clk = ~clk;

    traffic_light_actuated_controller dut (
        .clk       (clk),
        .reset     (reset),
`ifdef TLC_FLASH_EN
        .flash_req (flash_req),
`endif
        .car_NS    (car_NS),
        .car_EW    (car_EW),
        .ped_req   (ped_req),
        .light_NS  (light_NS),
        .light_EW  (light_EW),
        .walk      (walk),
        .state_o   (state_o)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks which phase the intersection is in and how many cycles it has
    // spent there (1 = first cycle), applying the timing rules directly.
    int m_phase;
    int m_elapsed;
    bit m_ped;
    bit m_ns_served_last;

    function automatic void model_reset();
        m_phase         = P_ALLRED;
        m_elapsed       = 1;
        m_ped           = 1'b0;
        m_ns_served_last = 1'b0;
    endfunction

    function automatic logic [7:0] expected_word(input int ph);
        logic [2:0] code;
        logic [1:0] ns, ew;
        logic       wk;
        code = ph[2:0];
        ns = (ph == P_NSG) ? 2'b10 : (ph == P_NSY) ? 2'b01 : 2'b00;
        ew = (ph == P_EWG) ? 2'b10 : (ph == P_EWY) ? 2'b01 : 2'b00;
        wk = (ph == P_WALK);
        return {code, ns, ew, wk};
    endfunction

    function automatic void model_step(input bit cns, input bit cew, input bit preq);
        int nxt;
        nxt = m_phase;
        case (m_phase)
            P_ALLRED: if (m_elapsed >= ALLRED) nxt = P_NSG;
            P_NSG: if ((m_elapsed >= MING && cew && !cns) ||
                       (m_elapsed >= GREEN && (cew || m_ped))) nxt = P_NSY;
            P_NSY: if (m_elapsed >= YELLOW) nxt = P_CLRNS;
            P_CLRNS: if (m_elapsed >= ALLRED) nxt = m_ped ? P_WALK : P_EWG;
            P_EWG: if ((m_elapsed >= MING && cns && !cew) ||
                       (m_elapsed >= GREEN && (cns || m_ped))) nxt = P_EWY;
            P_EWY: if (m_elapsed >= YELLOW) nxt = P_CLREW;
            P_CLREW: if (m_elapsed >= ALLRED) nxt = m_ped ? P_WALK : P_NSG;
            default: if (m_elapsed >= WALKC) nxt = m_ns_served_last ? P_EWG : P_NSG;
        endcase
        m_ped = preq | (m_ped & !(nxt == P_WALK && m_phase != P_WALK));
        if (nxt == P_NSG) m_ns_served_last = 1'b1;
        if (nxt == P_EWG) m_ns_served_last = 1'b0;
        m_elapsed = (nxt != m_phase) ? 1 : m_elapsed + 1;
        m_phase   = nxt;
        exp_q.push_back(expected_word(m_phase));
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; drives inputs, advances the model, checks
    // after the rising edge and returns at the next falling edge.
    task automatic cycle(input bit cns, input bit cew, input bit preq);
        logic [7:0] e;
        car_NS  = cns;
        car_EW  = cew;
        ped_req = preq;
        model_step(cns, cew, preq);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("state_o", state_o, e[7:5]);
        check("light_NS", light_NS, e[4:3]);
        check("light_EW", light_EW, e[2:1]);
        check("walk", walk, e[0]);
        check("safety_both_nonred", (light_NS != 2'b00) && (light_EW != 2'b00), 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        car_NS  = 1'b0;
        car_EW  = 1'b0;
        ped_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", state_o, P_ALLRED);
        check("reset_lamps", {light_NS, light_EW, walk}, 5'b00000);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    int cnt;
    int guard;
    bit rn, re;

    initial begin
        reset   = 1'b1;
        car_NS  = 1'b0;
        car_EW  = 1'b0;
        ped_req = 1'b0;
`ifdef TLC_FLASH_EN
        flash_req = 1'b0;
`endif

        // Idle: clearance then rest on NS green.
        do_reset();
        repeat (25) cycle(0, 0, 0);
        check("rest_on_ns_green", state_o, P_NSG);

        // EW demand only: NS gaps out after min green.
        do_reset();
        cnt = 0;
        repeat (14) begin
            cycle(0, 1, 0);
            if (light_NS == 2'b10) cnt++;
        end
        check("gap_out_ns_green_len", cnt, MING);
        check("ew_green_after_gap", light_EW, 2'b10);

        // Drive into EW_YELLOW, then pulse reset between edges.
        guard = 0;
        while (state_o != 3'(P_EWY) && guard < 10) begin
            cycle(1, 0, 0);
            guard++;
        end
        check("reached_ew_yellow", state_o, P_EWY);
        reset = 1'b1;
        #1;
        check("async_reset_state", state_o, P_ALLRED);
        check("async_reset_lamps", {light_NS, light_EW, walk}, 5'b00000);
        do_reset();
        repeat (10) cycle(0, 0, 0);
        check("restart_rest_green", state_o, P_NSG);

        // Both roads busy: full max-out rotation twice.
        do_reset();
        cnt = 0;
        repeat (56) begin
            cycle(1, 1, 0);
            if (light_EW == 2'b10) cnt++;
        end
        check("rotation_ew_green_cycles", cnt, 2 * GREEN);
        check("rotation_back_to_ns", state_o, P_NSG);

        // Pedestrian press during NS green, no cars.
        do_reset();
        repeat (3) cycle(0, 0, 0);
        cycle(0, 0, 1);
        cnt = 0;
        repeat (40) begin
            cycle(0, 0, 0);
            if (walk) cnt++;
        end
        check("ped_walk_len", cnt, WALKC);
        check("ped_then_ew_rest", state_o, P_EWG);

        // Randomized sensor levels and button presses.
        do_reset();
        rn = 1'b0;
        re = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rn = ~rn;
            if ($urandom_range(0, 7) == 0) re = ~re;
            cycle(rn, re, $urandom_range(0, 39) == 0);
        end

`ifdef TLC_FLASH_EN
        do_reset();
        repeat (5) cycle(1, 1, 0);
        flash_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            check("flash_state", state_o, P_ALLRED);
            check("flash_ns", light_NS, ((k / 4) % 2) ? 2'b11 : 2'b01);
            check("flash_ew", light_EW, ((k / 4) % 2) ? 2'b11 : 2'b00);
            check("flash_walk", walk, 0);
            @(negedge clk);
        end
        flash_req = 1'b0;
        @(posedge clk);
        #1;
        check("flash_release_state", state_o, P_ALLRED);
        check("flash_release_lamps", {light_NS, light_EW, walk}, 5'b00000);
        @(negedge clk);
        model_reset();
        exp_q.delete();
        repeat (4) cycle(0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
